// File: rtl/idle_deletion_ctrl_if.sv
// Block-side bundle between the idle-deletion controller and its upstream/FIFO neighbours.
// slave = controller view, master = driver (upstream + FIFO) view.
interface idle_deletion_ctrl_if #(
    parameter int NB_DATA   = 66,
    parameter int NB_CREDIT = 8
);
    logic                 i_valid;
    logic [NB_DATA-1:0]   i_data;
    logic                 i_fifo_empty;
    logic [NB_DATA-1:0]   o_data;
    logic                 o_write_enb;
    logic                 o_read_enb;
    logic                 o_am_insert;
    logic                 o_idle_deleted;
    logic [NB_CREDIT-1:0] o_credit;
    logic                 o_credit_sat;

    modport slave (
        input  i_valid, i_data, i_fifo_empty,
        output o_data, o_write_enb, o_read_enb, o_am_insert,
               o_idle_deleted, o_credit, o_credit_sat
    );

    modport master (
        output i_valid, i_data, i_fifo_empty,
        input  o_data, o_write_enb, o_read_enb, o_am_insert,
               o_idle_deleted, o_credit, o_credit_sat
    );
endinterface

// File: rtl/idle_deletion_ctrl.sv
// Idle-deletion controller in front of the PCS TX sync FIFO: deletes owed idle blocks
// and gates FIFO reads so N_AM slots per AM period stay free for alignment markers.
module idle_deletion_ctrl #(
    parameter int NB_DATA   = 66,
    parameter int AM_PERIOD = 16384,
    parameter int N_AM      = 20,
    parameter int NB_PERIOD = 14,
    parameter int NB_CREDIT = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    idle_deletion_ctrl_if.slave     ctrl_bus
);

    // Sum is wide enough to hold max credit plus one period's grant without wrapping.
    localparam int NB_SUM = NB_CREDIT + $clog2(N_AM + 1) + 1;

    localparam logic [NB_CREDIT-1:0] CREDIT_MAX   = '1;
    localparam logic [NB_SUM-1:0]    CREDIT_MAX_W = NB_SUM'(CREDIT_MAX);
    localparam logic [NB_SUM-1:0]    CREDIT_GRANT = NB_SUM'(N_AM);
    localparam logic [NB_PERIOD-1:0] PERIOD_LAST  = NB_PERIOD'(AM_PERIOD - 1);
    localparam logic [NB_PERIOD-1:0] AM_SLOTS     = NB_PERIOD'(N_AM);
    localparam logic [63:0]          IDLE_PAYLOAD = {8'h1E, 56'h0};

    logic [NB_PERIOD-1:0] period_cnt;
    logic [NB_CREDIT-1:0] credit;
    logic                 credit_sat;
    logic [NB_DATA-1:0]   data_q;
    logic                 write_enb_q;
    logic                 read_enb_q;
    logic                 am_insert_q;
    logic                 idle_deleted_q;

    logic                 advance;
    logic                 is_idle;
    logic                 deletion;
    logic                 am_slot;
    logic [NB_SUM-1:0]    credit_sum;
    logic [NB_CREDIT-1:0] credit_next;
    logic                 credit_hit_max;

    always_comb begin
        advance  = i_enable && ctrl_bus.i_valid;
        is_idle  = (ctrl_bus.i_data[NB_DATA-1 -: 2] == 2'b10) &&
                   (ctrl_bus.i_data[63:0] == IDLE_PAYLOAD);
        // Deletion spends credit held before this cycle; a grant arriving now is not yet usable.
        deletion = advance && is_idle && (credit != '0);
        am_slot  = period_cnt < AM_SLOTS;

        credit_sum = NB_SUM'(credit)
                   + ((period_cnt == '0) ? CREDIT_GRANT : '0)
                   - NB_SUM'(deletion);
        credit_hit_max = credit_sum >= CREDIT_MAX_W;
        credit_next    = credit_hit_max ? CREDIT_MAX : credit_sum[NB_CREDIT-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            period_cnt     <= '0;
            credit         <= '0;
            credit_sat     <= 1'b0;
            data_q         <= '0;
            write_enb_q    <= 1'b0;
            read_enb_q     <= 1'b0;
            am_insert_q    <= 1'b0;
            idle_deleted_q <= 1'b0;
        end else begin
            write_enb_q    <= advance && !deletion;
            idle_deleted_q <= deletion;
            am_insert_q    <= advance && am_slot;
            read_enb_q     <= advance && !am_slot && !ctrl_bus.i_fifo_empty;

            if (advance) begin
                data_q     <= ctrl_bus.i_data;
                period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + NB_PERIOD'(1);
                credit     <= credit_next;
                if (credit_hit_max) begin
                    credit_sat <= 1'b1;
                end
            end
        end
    end

    assign ctrl_bus.o_data         = data_q;
    assign ctrl_bus.o_write_enb    = write_enb_q;
    assign ctrl_bus.o_read_enb     = read_enb_q;
    assign ctrl_bus.o_am_insert    = am_insert_q;
    assign ctrl_bus.o_idle_deleted = idle_deleted_q;
    assign ctrl_bus.o_credit       = credit;
    assign ctrl_bus.o_credit_sat   = credit_sat;

endmodule

// File: tb/tb_idle_deletion_ctrl.sv
// Bench for idle_deletion_ctrl with a shrunken AM period; a slot/credit reference model
// predicts every output each cycle from the block-level rules.
module tb_idle_deletion_ctrl;

    localparam int NB_DATA   = 66;
    localparam int AM_PERIOD = 8;
    localparam int N_AM      = 2;
    localparam int NB_PERIOD = 3;
    localparam int NB_CREDIT = 3;
    localparam int CRED_MAX  = (1 << NB_CREDIT) - 1;
    localparam int NB_OBS    = NB_DATA + 4 + NB_CREDIT + 1;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_enable = 1'b0;

    idle_deletion_ctrl_if #(.NB_DATA(NB_DATA), .NB_CREDIT(NB_CREDIT)) bus ();

    idle_deletion_ctrl #(
        .NB_DATA  (NB_DATA),
        .AM_PERIOD(AM_PERIOD),
        .N_AM     (N_AM),
        .NB_PERIOD(NB_PERIOD),
        .NB_CREDIT(NB_CREDIT)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_enable(i_enable),
        .ctrl_bus(bus)
    );

    always #5 i_clock = ~i_clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state: slot index within the period and credit as plain integers.
    int                 m_slot;
    int                 m_credit;
    bit                 m_sat;
    logic [NB_DATA-1:0] m_data;
    bit                 m_we, m_re, m_am, m_del;

    function automatic logic [NB_DATA-1:0] idle_block();
        return {2'b10, 8'h1E, 56'h0};
    endfunction

    function automatic logic [NB_DATA-1:0] non_idle_block();
        logic [NB_DATA-1:0] b;
        b = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 2))
            0: b[65:64] = 2'b01;
            1: begin b[65:64] = 2'b10; b[63:56] = 8'h1E; b[$urandom_range(0, 55)] = 1'b1; end
            default: begin b[65:64] = 2'b10; if (b[63:56] == 8'h1E) b[56] = 1'b1; end
        endcase
        return b;
    endfunction

    function automatic logic [NB_OBS-1:0] obs_vec();
        return {bus.o_data, bus.o_write_enb, bus.o_read_enb, bus.o_am_insert,
                bus.o_idle_deleted, bus.o_credit, bus.o_credit_sat};
    endfunction

    function automatic logic [NB_OBS-1:0] exp_vec();
        return {m_data, m_we, m_re, m_am, m_del, NB_CREDIT'(m_credit), m_sat};
    endfunction

    task automatic model_clear();
        m_slot = 0; m_credit = 0; m_sat = 0; m_data = '0;
        m_we = 0; m_re = 0; m_am = 0; m_del = 0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_enable = 1'($urandom);
        bus.i_valid = 1'($urandom);
        bus.i_data = non_idle_block();
        bus.i_fifo_empty = 1'($urandom);
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        model_clear();
    endtask

    // Drive one cycle and advance the model by the same block-level rules.
    task automatic step(input bit en, input bit v, input logic [NB_DATA-1:0] d, input bit fe);
        bit adv, idle, am;
        int nc;
        i_enable = en; bus.i_valid = v; bus.i_data = d; bus.i_fifo_empty = fe;
        adv  = en && v;
        idle = (d == idle_block());
        if (adv) begin
            am    = m_slot < N_AM;
            m_del = idle && (m_credit > 0);
            m_we  = !m_del;
            m_am  = am;
            m_re  = !am && !fe;
            m_data = d;
            nc = m_credit + ((m_slot == 0) ? N_AM : 0) - (m_del ? 1 : 0);
            if (nc >= CRED_MAX) begin
                nc = CRED_MAX;
                m_sat = 1;
            end
            m_credit = nc;
            m_slot = (m_slot + 1) % AM_PERIOD;
        end else begin
            m_we = 0; m_re = 0; m_am = 0; m_del = 0;
        end
        @(posedge i_clock); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", obs_vec());
        end
    endtask

    task automatic test_non_idle();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 1, non_idle_block(), 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL non_idle blk%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.o_credit !== NB_CREDIT'(6)) begin
            failures++;
            $display("FAIL non_idle_credit got=%0d want=6", bus.o_credit);
        end
    endtask

    task automatic test_all_idle();
        int dels = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 1, idle_block(), 0);
            dels += int'(bus.o_idle_deleted);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL all_idle blk%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (dels != 4) begin
            failures++;
            $display("FAIL all_idle_count got=%0d want=4", dels);
        end
    endtask

    task automatic test_alternating();
        int dels = 0;
        do_reset();
        // Build credit 3: grant 2, spend 1, grant 2 at the next period start.
        step(1, 1, non_idle_block(), 0);
        step(1, 1, idle_block(), 0);
        for (int i = 0; i < 6; i++) step(1, 1, non_idle_block(), 0);
        step(1, 1, non_idle_block(), 0);
        checks++;
        if (bus.o_credit !== NB_CREDIT'(3)) begin
            failures++;
            $display("FAIL alt_setup_credit got=%0d want=3", bus.o_credit);
        end
        for (int i = 0; i < 7; i++) begin
            step(1, 1, (i % 2 == 0) ? idle_block() : non_idle_block(), 0);
            dels += int'(bus.o_idle_deleted);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL alternating blk%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (dels != 3 || bus.o_credit !== '0) begin
            failures++;
            $display("FAIL alt_result dels=%0d credit=%0d want dels=3 credit=0", dels, bus.o_credit);
        end
    endtask

    task automatic test_valid_gap();
        logic [NB_DATA-1:0] last;
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, non_idle_block(), 0);
        last = m_data;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, idle_block(), 1'($urandom));
            checks++;
            if (obs_vec() !== exp_vec() || bus.o_data !== last) begin
                failures++;
                $display("FAIL valid_gap cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, idle_block(), 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL valid_resume blk%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, non_idle_block(), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, idle_block(), 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL enable_hold cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4 * AM_PERIOD; i++) step(1, 1, non_idle_block(), 0);
        checks++;
        if (bus.o_credit !== NB_CREDIT'(CRED_MAX) || bus.o_credit_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_reach credit=%0d sat=%b want credit=%0d sat=1",
                     bus.o_credit, bus.o_credit_sat, CRED_MAX);
        end
        // Spend credit below max; the flag must stay set.
        for (int i = 0; i < 3; i++) step(1, 1, idle_block(), 0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.o_credit_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_sticky got=%h want=%h", obs_vec(), exp_vec());
        end
        do_reset();
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL sat_reset got=%h want=0", obs_vec());
        end
        step(1, 1, non_idle_block(), 0);
        checks++;
        if (bus.o_am_insert !== 1'b1 || bus.o_credit !== NB_CREDIT'(N_AM)) begin
            failures++;
            $display("FAIL restart_slot0 am=%b credit=%0d want am=1 credit=%0d",
                     bus.o_am_insert, bus.o_credit, N_AM);
        end
    endtask

    task automatic test_fifo_empty();
        do_reset();
        for (int i = 0; i < N_AM; i++) step(1, 1, non_idle_block(), 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, non_idle_block(), 1);
            checks++;
            if (obs_vec() !== exp_vec() || bus.o_read_enb !== 1'b0) begin
                failures++;
                $display("FAIL fifo_empty_gate cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        step(1, 1, non_idle_block(), 0);
        checks++;
        if (bus.o_read_enb !== 1'b1) begin
            failures++;
            $display("FAIL fifo_empty_release got=%b want=1", bus.o_read_enb);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                     ($urandom_range(0, 1) == 1) ? idle_block() : non_idle_block(),
                     $urandom_range(0, 3) == 0);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        bus.i_fifo_empty = 1'b0;
        model_clear();
        @(posedge i_clock); #1;
        test_reset();
        test_non_idle();
        test_all_idle();
        test_alternating();
        test_valid_gap();
        test_enable_hold();
        test_saturation();
        test_fifo_empty();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
